// File: rtl/usbh_report_decoder_gen.sv
// HID gamepad report -> NES button vector: axis hysteresis, hat, autofire, report watchdog.
// Optional combo-toggled turbo latches are built when REPORT_DECODER_TURBO_EN is defined.

module usbh_report_decoder_gen_axis #(
  parameter int C_THRESH_LO = 64,
  parameter int C_THRESH_HI = 192,
  parameter int C_HYST      = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_clr,
  input  logic       i_upd,
  input  logic [7:0] i_v,
  output logic       o_neg,
  output logic       o_pos
);
  typedef enum logic [1:0] {CENTER = 2'd0, NEG = 2'd1, POS = 2'd2} axis_e;

  // 9-bit thresholds so LO+HYST cannot wrap
  localparam logic [8:0] LO9      = 9'(C_THRESH_LO);
  localparam logic [8:0] HI9      = 9'(C_THRESH_HI);
  localparam logic [8:0] NEG_EXIT = 9'(C_THRESH_LO + C_HYST);
  localparam logic [8:0] POS_EXIT = 9'(C_THRESH_HI - C_HYST);

  axis_e      state_q, state_d;
  logic [8:0] v9;

  assign v9 = {1'b0, i_v};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= CENTER;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clr) begin
      state_d = CENTER;
    end else if (i_upd) begin
      case (state_q)
        CENTER: if (v9 < LO9) state_d = NEG;
                else if (v9 > HI9) state_d = POS;
        NEG:    if (v9 > HI9) state_d = POS;
                else if (v9 >= NEG_EXIT) state_d = CENTER;
        POS:    if (v9 < LO9) state_d = NEG;
                else if (v9 <= POS_EXIT) state_d = CENTER;
        default: state_d = CENTER;
      endcase
    end
  end

  assign o_neg = (state_q == NEG);
  assign o_pos = (state_q == POS);
endmodule

module usbh_report_decoder_gen #(
  parameter int C_REPORT_BYTES = 8,
  parameter int C_CLK_HZ       = 6000000,
  parameter int C_AUTOFIRE_HZ  = 10,
  parameter int C_TIMEOUT_MS   = 100,
  parameter int C_X_BYTE       = 0,
  parameter int C_Y_BYTE       = 1,
  parameter int C_THRESH_LO    = 64,
  parameter int C_THRESH_HI    = 192,
  parameter int C_HYST         = 16,
  parameter int C_HAT_BIT      = 40,
  parameter int C_A_BIT        = 46,
  parameter int C_B_BIT        = 45,
  parameter int C_SEL_BIT      = 52,
  parameter int C_START_BIT    = 53,
  parameter int C_AFA_BIT      = 50,
  parameter int C_AFB_BIT      = 51
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [8*C_REPORT_BYTES-1:0] i_report,
  input  logic                        i_report_valid,
  output logic [7:0]                  o_btn,
  output logic                        o_btn_valid,
  output logic                        o_connected,
  output logic [1:0]                  o_turbo
);
  localparam int STAGES   = 2;
  localparam int AF_HALF  = C_CLK_HZ / (2 * C_AUTOFIRE_HZ);
  localparam int AF_W     = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  localparam int WD_LIMIT = C_CLK_HZ / 1000 * C_TIMEOUT_MS;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  logic [8*C_REPORT_BYTES-1:0] report_q;
  logic [STAGES:1]             vld_pipe_q;
  logic [WD_W-1:0]             wd_q;
  logic                        conn_q, expire;
  logic [AF_W-1:0]             af_cnt_q;
  logic                        phase_q;
  logic [7:0]                  dec_q, dec_d;   // {hatR,hatL,hatD,hatU,START,SEL,B,A}
  logic [1:0]                  af_q, af_d;     // {AFB,AFA}
  logic [3:0]                  hat_dirs;
  logic [1:0][7:0]             axis_v;
  logic [1:0]                  axis_neg, axis_pos;
  logic [3:0]                  dirs;
  logic [1:0]                  ab;
  logic                        unused_report;

  assign unused_report = ^report_q;

  // A report on the expiry cycle wins, so expiry only fires without a strobe
  assign expire = !i_report_valid && (wd_q == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      report_q   <= '0;
      vld_pipe_q <= '0;
    end else begin
      if (i_report_valid) report_q <= i_report;
      vld_pipe_q[1] <= i_report_valid;
      vld_pipe_q[2] <= vld_pipe_q[1] & ~expire;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wd_q   <= '0;
      conn_q <= 1'b0;
    end else if (i_report_valid) begin
      wd_q   <= '0;
      conn_q <= 1'b1;
    end else if (wd_q != WD_W'(WD_LIMIT)) begin
      wd_q <= wd_q + WD_W'(1);
      if (expire) conn_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      af_cnt_q <= '0;
      phase_q  <= 1'b0;
    end else if (af_cnt_q == AF_W'(AF_HALF - 1)) begin
      af_cnt_q <= '0;
      phase_q  <= ~phase_q;
    end else begin
      af_cnt_q <= af_cnt_q + AF_W'(1);
    end
  end

  // hat_dirs = {R,L,D,U}
  always_comb begin
    hat_dirs = 4'b0000;
    case (report_q[C_HAT_BIT +: 4])
      4'd0:    hat_dirs = 4'b0001;
      4'd1:    hat_dirs = 4'b1001;
      4'd2:    hat_dirs = 4'b1000;
      4'd3:    hat_dirs = 4'b1010;
      4'd4:    hat_dirs = 4'b0010;
      4'd5:    hat_dirs = 4'b0110;
      4'd6:    hat_dirs = 4'b0100;
      4'd7:    hat_dirs = 4'b0101;
      default: hat_dirs = 4'b0000;
    endcase
  end

  assign dec_d = {hat_dirs, report_q[C_START_BIT], report_q[C_SEL_BIT],
                  report_q[C_B_BIT], report_q[C_A_BIT]};
  assign af_d  = {report_q[C_AFB_BIT], report_q[C_AFA_BIT]};

  always_ff @(posedge i_clk) begin
    if (!i_rstn || expire) begin
      dec_q <= '0;
      af_q  <= '0;
    end else if (vld_pipe_q[1]) begin
      dec_q <= dec_d;
      af_q  <= af_d;
    end
  end

  assign axis_v[0] = report_q[C_X_BYTE*8 +: 8];
  assign axis_v[1] = report_q[C_Y_BYTE*8 +: 8];

  for (genvar g = 0; g < 2; g++) begin : g_axis
    usbh_report_decoder_gen_axis #(
      .C_THRESH_LO(C_THRESH_LO),
      .C_THRESH_HI(C_THRESH_HI),
      .C_HYST     (C_HYST)
    ) u_axis (
      .i_clk (i_clk),
      .i_rstn(i_rstn),
      .i_clr (expire),
      .i_upd (vld_pipe_q[1]),
      .i_v   (axis_v[g]),
      .o_neg (axis_neg[g]),
      .o_pos (axis_pos[g])
    );
  end

  assign dirs = dec_q[7:4] | {axis_pos[0], axis_neg[0], axis_pos[1], axis_neg[1]};

`ifdef REPORT_DECODER_TURBO_EN
  logic [1:0] turbo_q, combo_q, combo_d, plain;

  assign combo_d = {report_q[C_SEL_BIT] & report_q[C_B_BIT],
                    report_q[C_SEL_BIT] & report_q[C_A_BIT]};

  always_ff @(posedge i_clk) begin
    if (!i_rstn || expire) begin
      turbo_q <= '0;
      combo_q <= '0;
    end else if (vld_pipe_q[1]) begin
      combo_q <= combo_d;
      turbo_q <= turbo_q ^ (combo_d & ~combo_q);
    end
  end

  // held combo masks its A/B so the toggle gesture is not seen as a press
  assign plain   = dec_q[1:0] & (~turbo_q | {2{phase_q}});
  assign ab      = (plain | (af_q & {2{phase_q}})) & ~combo_q;
  assign o_turbo = turbo_q;
`else
  assign ab      = dec_q[1:0] | (af_q & {2{phase_q}});
  assign o_turbo = 2'b00;
`endif

  assign o_btn       = conn_q ? {dirs, dec_q[3:2], ab} : 8'h00;
  assign o_btn_valid = vld_pipe_q[2];
  assign o_connected = conn_q;
endmodule

// File: tb/tb_usbh_report_decoder_gen.sv
// Directed bench with an o_btn scoreboard; uses a scaled clock so timers stay short.

module tb_usbh_report_decoder_gen;
  localparam int CLK_HZ = 20000;
  localparam int AF_HZ  = 10;
  localparam int TO_MS  = 500;
  localparam int HALF   = CLK_HZ / (2 * AF_HZ);   // 1000
  localparam int LIMIT  = CLK_HZ / 1000 * TO_MS;  // 10000

  localparam logic [5:0] B_A = 6'b000001, B_B = 6'b000010, B_SEL = 6'b000100,
                         B_START = 6'b001000, B_AFA = 6'b010000, B_NONE = 6'b000000;

  typedef struct {
    logic [7:0] btn;
    logic [7:0] mask;
    int         cyc;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [63:0] i_report = '0;
  logic        i_report_valid = 1'b0;
  logic [7:0]  o_btn;
  logic        o_btn_valid, o_connected;
  logic [1:0]  o_turbo;

  int   n_chk = 0, n_pass = 0, cyc = 0, s_last = 0;
  exp_t sb[$];

  usbh_report_decoder_gen #(
    .C_REPORT_BYTES(8), .C_CLK_HZ(CLK_HZ), .C_AUTOFIRE_HZ(AF_HZ), .C_TIMEOUT_MS(TO_MS)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_report(i_report), .i_report_valid(i_report_valid),
    .o_btn(o_btn), .o_btn_valid(o_btn_valid), .o_connected(o_connected), .o_turbo(o_turbo)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mk(input logic [7:0] x, input logic [7:0] y,
                                     input logic [3:0] hat, input logic [5:0] b);
    logic [63:0] r;
    r = '0;
    r[7:0] = x; r[15:8] = y; r[43:40] = hat;
    r[46] = b[0]; r[45] = b[1]; r[52] = b[2]; r[53] = b[3]; r[50] = b[4]; r[51] = b[5];
    return r;
  endfunction

  // drives one strobe cycle; output must appear two edges later
  task automatic strobe(input logic [63:0] rep, input logic [7:0] exp, input logic [7:0] mask,
                        input bit push);
    exp_t e;
    @(negedge i_clk);
    i_report = rep;
    i_report_valid = 1'b1;
    s_last = cyc;
    if (push) begin
      e.btn = exp; e.mask = mask; e.cyc = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    i_report_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_b0(input int bound, output int t, output bit ok);
    logic prev;
    prev = o_btn[0];
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge i_clk);
      if (o_btn[0] !== prev) begin
        t = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic af_period(input string tag);
    int  t0, t1, t2;
    bit  ok0, ok1, ok2;
    wait_b0(2 * HALF + 10, t0, ok0);
    wait_b0(2 * HALF + 10, t1, ok1);
    wait_b0(2 * HALF + 10, t2, ok2);
    check({tag, "_toggles_seen"}, {ok0, ok1, ok2}, 3'b111);
    check({tag, "_half1"}, t1 - t0, HALF);
    check({tag, "_half2"}, t2 - t1, HALF);
  endtask

  // scoreboard: every o_btn_valid pulse must match the oldest pending report
  always @(negedge i_clk) begin
    if (o_btn_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", o_btn_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("btn", o_btn & e.mask, e.btn & e.mask);
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge i_clk);
    $display("FAIL global_timeout: observed cycle %0d expected finish earlier", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int  changes, s_prev;
    logic [7:0] prev_btn;

    repeat (3) @(negedge i_clk);
    check("rst_btn", o_btn, 8'h00);
    check("rst_valid", o_btn_valid, 1'b0);
    check("rst_conn", o_connected, 1'b0);
    check("rst_turbo", o_turbo, 2'b00);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);

    // hat decode (hat 3 = D+R, hat 1 = U+R)
    strobe(mk(128, 128, 4'd3, B_NONE), 8'b1010_0000, 8'hFF, 1);
    @(negedge i_clk);
    i_report_valid = 1'b0;
    check("conn_after_first", o_connected, 1'b1);
    idle(3);
    strobe(mk(128, 128, 4'd1, B_NONE), 8'b1001_0000, 8'hFF, 1);
    strobe(mk(128, 128, 4'd8, B_NONE), 8'h00, 8'hFF, 1);
    idle(3);

    // X hysteresis, back-to-back strobes
    strobe(mk(50,  128, 4'hF, B_NONE), 8'h40, 8'hFF, 1);
    strobe(mk(70,  128, 4'hF, B_NONE), 8'h40, 8'hFF, 1);
    strobe(mk(79,  128, 4'hF, B_NONE), 8'h40, 8'hFF, 1);
    strobe(mk(80,  128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    strobe(mk(128, 128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    strobe(mk(200, 128, 4'hF, B_NONE), 8'h80, 8'hFF, 1);
    strobe(mk(180, 128, 4'hF, B_NONE), 8'h80, 8'hFF, 1);
    strobe(mk(176, 128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    strobe(mk(10,  128, 4'hF, B_NONE), 8'h40, 8'hFF, 1);
    strobe(mk(250, 128, 4'hF, B_NONE), 8'h80, 8'hFF, 1);
    strobe(mk(128, 128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    // threshold edges
    strobe(mk(64,  128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    strobe(mk(192, 128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    strobe(mk(63,  128, 4'hF, B_NONE), 8'h40, 8'hFF, 1);
    strobe(mk(193, 128, 4'hF, B_NONE), 8'h80, 8'hFF, 1);
    strobe(mk(177, 128, 4'hF, B_NONE), 8'h80, 8'hFF, 1);
    strobe(mk(128, 128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    // Y axis
    strobe(mk(128, 10,  4'hF, B_NONE), 8'h10, 8'hFF, 1);
    strobe(mk(128, 63,  4'hF, B_NONE), 8'h10, 8'hFF, 1);
    strobe(mk(128, 250, 4'hF, B_NONE), 8'h20, 8'hFF, 1);
    strobe(mk(128, 192, 4'hF, B_NONE), 8'h20, 8'hFF, 1);
    strobe(mk(128, 128, 4'hF, B_NONE), 8'h00, 8'hFF, 1);
    idle(3);

    // plain buttons and hat OR axis
    strobe(mk(128, 128, 4'hF, B_START | B_B | B_A), 8'h0B, 8'hFF, 1);
    strobe(mk(128, 128, 4'hF, B_SEL), 8'h04, 8'hFF, 1);
    strobe(mk(50,  128, 4'd6, B_NONE), 8'h40, 8'hFF, 1);
    strobe(mk(128, 250, 4'd0, B_NONE), 8'h30, 8'hFF, 1);
    strobe(mk(128, 128, 4'd7, B_NONE), 8'h50, 8'hFF, 1);
    idle(3);

    // autofire A: bit0 follows the phase with no further reports
    strobe(mk(128, 128, 4'hF, B_AFA), 8'h00, 8'hFE, 1);
    idle(3);
    af_period("afa");

    // plain A: steady
    strobe(mk(128, 128, 4'hF, B_A), 8'h01, 8'hFF, 1);
    idle(3);
    changes = 0;
    prev_btn = o_btn;
    for (int i = 0; i < 2 * HALF + 10; i++) begin
      @(negedge i_clk);
      if (o_btn !== prev_btn) changes++;
      prev_btn = o_btn;
    end
    check("plain_a_level", o_btn, 8'h01);
    check("plain_a_changes", changes, 0);

    // report on the would-expire cycle keeps the link up
    s_prev = s_last;
    for (int i = 0; i < LIMIT + 10 && cyc != s_prev + LIMIT - 1; i++) @(negedge i_clk);
    check("pre_expire_conn", o_connected, 1'b1);
    strobe(mk(128, 128, 4'hF, B_A), 8'h01, 8'hFF, 1);
    check("race_cycle", s_last, s_prev + LIMIT);
    @(negedge i_clk);
    i_report_valid = 1'b0;
    check("race_conn", o_connected, 1'b1);
    idle(3);
    check("race_conn_hold", o_connected, 1'b1);

    // timeout
    for (int i = 0; i < LIMIT + 20 && o_connected !== 1'b0; i++) @(negedge i_clk);
    check("to_disconnect", o_connected, 1'b0);
    check("to_cycle", cyc - s_last, LIMIT + 1);
    check("to_btn", o_btn, 8'h00);
    check("to_valid", o_btn_valid, 1'b0);
    idle(5);
    check("to_btn_stays", o_btn, 8'h00);

    // reconnect
    strobe(mk(128, 128, 4'hF, B_A), 8'h01, 8'hFF, 1);
    @(negedge i_clk);
    i_report_valid = 1'b0;
    check("reconn", o_connected, 1'b1);
    idle(3);

`ifdef REPORT_DECODER_TURBO_EN
    strobe(mk(128, 128, 4'hF, B_SEL | B_A), 8'h04, 8'hFF, 1);
    idle(3);
    check("turbo_a_on", o_turbo, 2'b01);
    strobe(mk(128, 128, 4'hF, B_A), 8'h00, 8'hFE, 1);
    idle(3);
    af_period("turbo_a");
    strobe(mk(128, 128, 4'hF, B_SEL | B_A), 8'h04, 8'hFF, 1);
    idle(3);
    check("turbo_a_off", o_turbo, 2'b00);
    strobe(mk(128, 128, 4'hF, B_A), 8'h01, 8'hFF, 1);
    strobe(mk(128, 128, 4'hF, B_SEL | B_B), 8'h04, 8'hFF, 1);
    idle(3);
    check("turbo_b_on", o_turbo, 2'b10);
`else
    strobe(mk(128, 128, 4'hF, B_SEL | B_A), 8'h05, 8'hFF, 1);
    idle(3);
    check("turbo_tied", o_turbo, 2'b00);
`endif

    // reset mid-pipeline: strobe, then reset on the next edge
    @(negedge i_clk);
    i_rstn = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    strobe(mk(128, 128, 4'd4, B_A), 8'h00, 8'hFF, 0);
    @(negedge i_clk);
    i_report_valid = 1'b0;
    i_rstn = 1'b0;
    check("midrst_btn0", o_btn, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check("midrst_valid", o_btn_valid, 1'b0);
      check("midrst_btn", o_btn, 8'h00);
    end
    check("midrst_conn", o_connected, 1'b0);
    check("midrst_turbo", o_turbo, 2'b00);
    i_rstn = 1'b1;
    idle(4);
    check("midrst_conn_after", o_connected, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
